mmm_nlp_redc_ctrl: RTL

Montgomery sequencer for the 90-bit NLP datapath. It takes operands a and b, plus modulus N and NP = −N⁻¹ mod 2^90, and returns a·b·2^-90 mod N. It drives the external pipelined multiplier `mmm_nlp_90b` (instantiated alongside it) three times: T = a·b, m = (T mod R)·NP, then m·N. It then performs the reduction add, shift and conditional subtract. It sits directly upstream and downstream of the multiplier: it supplies its operands and consumes its 181-bit result.

---
 rtl/mmm_nlp_pkg.sv | 16 +
 rtl/mmm_nlp_csub.sv | 11 +
 rtl/mmm_nlp_redc_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/mmm_nlp_pkg.sv
// mmm_nlp_pkg: shared widths, latency and FSM states for the Montgomery sequencer
package mmm_nlp_pkg;
  localparam int IDW     = 90;
  localparam int ODW     = 181;
  localparam int MUL_LAT = 4;
  localparam int RDW     = IDW + 1;
  localparam int CW      = 3;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_T,
    ST_MUL_M,
    ST_MUL_MN,
    ST_ADD,
    ST_SUB
  } state_e;
endpackage

// File: rtl/mmm_nlp_csub.sv
// mmm_nlp_csub: final conditional subtract, reduces u < 2N into [0, N)
module mmm_nlp_csub
  import mmm_nlp_pkg::*;
(
  input  logic [RDW-1:0] u_i,
  input  logic [IDW-1:0] n_i,
  output logic [IDW-1:0] r_o
);
  // u - N always fits in IDW bits when taken, so a truncated subtract is exact
  assign r_o = (u_i >= {1'b0, n_i}) ? u_i[IDW-1:0] - n_i : u_i[IDW-1:0];
endmodule

// File: rtl/mmm_nlp_redc_ctrl.sv
// mmm_nlp_redc_ctrl: sequences three multiplies and the REDC add/shift/subtract
module mmm_nlp_redc_ctrl
  import mmm_nlp_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_vld,
  output logic           o_rdy,
  input  logic [IDW-1:0] i_a,
  input  logic [IDW-1:0] i_b,
  input  logic [IDW-1:0] i_n,
  input  logic [IDW-1:0] i_np,
  output logic [IDW-1:0] o_mul_a,
  output logic [IDW-1:0] o_mul_b,
  input  logic [ODW-1:0] i_mul_res,
  output logic           o_vld,
  output logic [IDW-1:0] o_res
);
  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [IDW-1:0] n_q, np_q, mul_a_q, mul_b_q, res_q;
  logic [ODW-1:0] t_q, p_q, s;
  logic [RDW-1:0] u_q;
  logic [IDW-1:0] r;
  logic           vld_q, last, s_lo_unused;
  assign last        = cnt_q == CW'(MUL_LAT);
  assign s           = t_q + p_q;
  assign s_lo_unused = ^s[IDW-1:0];
  assign o_rdy       = state_q == ST_IDLE;
  assign o_vld       = vld_q;
  assign o_res       = res_q;
  assign o_mul_a     = mul_a_q;
  assign o_mul_b     = mul_b_q;
  mmm_nlp_csub u_csub (.u_i(u_q), .n_i(n_q), .r_o(r));
  // FSM: latch request, walk the three multiply phases, then add/shift and subtract
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      np_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      t_q     <= '0;
      p_q     <= '0;
      u_q     <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      cnt_q <= (state_q inside {ST_MUL_T, ST_MUL_M, ST_MUL_MN}) && !last ? cnt_q + 1'b1 : '0;
      case (state_q)
        ST_IDLE: if (i_vld) begin
          n_q     <= i_n;
          np_q    <= i_np;
          mul_a_q <= i_a;
          mul_b_q <= i_b;
          state_q <= ST_MUL_T;
        end
        ST_MUL_T: if (last) begin
          t_q     <= i_mul_res;
          mul_a_q <= i_mul_res[IDW-1:0];
          mul_b_q <= np_q;
          state_q <= ST_MUL_M;
        end
        ST_MUL_M: if (last) begin
          mul_a_q <= i_mul_res[IDW-1:0];
          mul_b_q <= n_q;
          state_q <= ST_MUL_MN;
        end
        ST_MUL_MN: if (last) begin
          p_q     <= i_mul_res;
          state_q <= ST_ADD;
        end
        ST_ADD: begin
          u_q     <= s[ODW-1:IDW];
          state_q <= ST_SUB;
        end
        ST_SUB: begin
          res_q   <= r;
          vld_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
